mem_wb_pipe_reg: RTL

Parametrised MEM→WB pipeline register for the ARM-style core, sitting between the memory stage and the register-file write-back port. It carries the write-back control bits, ALU result, memory read data and destination register with a valid/ready handshake, synchronous flush, and an optional skid entry so that `in_ready` is driven from a flop. It also provides the selected write-back value and a forwarding tap for the hazard unit.

---
 rtl/mem_wb_pipe_reg.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, synchronous flush,
// optional skid entry (registered in_ready), write-back value select and a
// forwarding tap for the hazard unit.
module mem_wb_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int SKID       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wb_en,
    input  logic                  in_mem_r_en,
    input  logic [DATA_W-1:0]     in_alu_res,
    input  logic [DATA_W-1:0]     in_mem_out,
    input  logic [REG_ADDR_W-1:0] in_dest,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_wb_en,
    output logic                  out_mem_r_en,
    output logic [DATA_W-1:0]     out_alu_res,
    output logic [DATA_W-1:0]     out_mem_out,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [DATA_W-1:0]     out_wb_value,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_dest
);

    // Payload layout: {wb_en, mem_r_en, alu_res, mem_out, dest}
    localparam int PW = 2 + 2 * DATA_W + REG_ADDR_W;

    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] main_data_q,  main_data_d;
    logic [PW-1:0] skid_data_q,  skid_data_d;
    logic [PW-1:0] in_data_s;
    logic          accept_s;
    logic          consume_s;

    assign in_data_s = {in_wb_en, in_mem_r_en, in_alu_res, in_mem_out, in_dest};

    // Ready: with a skid entry it depends only on flops; without, it passes out_ready through.
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
        end else if (SKID != 0) begin
            in_ready = !skid_valid_q;
        end else begin
            in_ready = !main_valid_q || out_ready;
        end
    end

    assign accept_s  = in_valid && in_ready;
    assign consume_s = main_valid_q && out_ready;

    // Next-state: flush beats everything; skid drains into main before any new beat lands.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            // Valid bits drop; data flops keep their last contents.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if ((SKID != 0) && skid_valid_q && consume_s) begin
            // in_ready is low here, so no accept can collide with the drain.
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (accept_s && (!main_valid_q || consume_s)) begin
            main_data_d  = in_data_s;
            main_valid_d = 1'b1;
        end else if (accept_s) begin
            // Main full and stalled: the extra beat parks in the skid entry.
            skid_data_d  = in_data_s;
            skid_valid_d = 1'b1;
        end else if (consume_s) begin
            main_valid_d = 1'b0;
        end else begin
            main_valid_d = main_valid_q;
        end
    end

    // State registers with synchronous reset clearing valids and all data.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid    = main_valid_q;
    assign out_wb_en    = main_data_q[PW-1];
    assign out_mem_r_en = main_data_q[PW-2];
    assign out_alu_res  = main_data_q[REG_ADDR_W+DATA_W +: DATA_W];
    assign out_mem_out  = main_data_q[REG_ADDR_W +: DATA_W];
    assign out_dest     = main_data_q[REG_ADDR_W-1:0];

    // Write-back value select: loads return memory data, everything else the ALU result.
    always_comb begin
        out_wb_value = '0;
        if (out_mem_r_en) begin
            out_wb_value = out_mem_out;
        end else begin
            out_wb_value = out_alu_res;
        end
    end

    assign fwd_valid = out_valid && out_wb_en;
    assign fwd_dest  = out_dest;

endmodule
